// File: rtl/gpio_pkg.sv
// gpio_pkg
//   Shared constants and helpers for the GPIO interrupt controller.
//   - Register offsets (byte addresses within the 8-bit decoded window)
//   - ADDR_BITS: number of address bits decoded locally
//   - be_mask(): expands a 4-bit byte-enable into a 32-bit lane mask
package gpio_pkg;

  localparam int ADDR_BITS = 8;

  localparam logic [ADDR_BITS-1:0] GPIO_OUT        = 8'h00;
  localparam logic [ADDR_BITS-1:0] GPIO_SET        = 8'h04;
  localparam logic [ADDR_BITS-1:0] GPIO_CLR        = 8'h08;
  localparam logic [ADDR_BITS-1:0] GPIO_TGL        = 8'h0C;
  localparam logic [ADDR_BITS-1:0] GPIO_IN         = 8'h10;
  localparam logic [ADDR_BITS-1:0] GPIO_RISE_EN    = 8'h14;
  localparam logic [ADDR_BITS-1:0] GPIO_FALL_EN    = 8'h18;
  localparam logic [ADDR_BITS-1:0] GPIO_IRQ_STATUS = 8'h1C;

  // First offset past the implemented register block.
  localparam logic [ADDR_BITS-1:0] GPIO_REG_END    = 8'h20;

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      m[i*8 +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/gpio_edge_sync.sv
// gpio_edge_sync
//   Multi-stage synchroniser for asynchronous input pins, followed by one
//   extra flop holding the previous synchronised value for edge detection.
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-low reset
//   din      in   WIDTH  asynchronous pin values
//   sync_val out  WIDTH  final synchroniser stage
//   rise     out  WIDTH  sync_val & ~prev (combinational)
//   fall     out  WIDTH  ~sync_val & prev (combinational)
module gpio_edge_sync #(
  parameter int WIDTH  = 12,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sync_val,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]             r_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_sync[0] <= din;
      for (int unsigned s = 1; s < STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign sync_val = r_sync[STAGES-1];
  assign rise     = r_sync[STAGES-1] & ~r_prev;
  assign fall     = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/gpio_irq_controller.sv
// gpio_irq_controller
//   Parametrised GPIO block on the core data bus with atomic set/clear/
//   toggle of outputs and per-pin rising/falling edge interrupts collected
//   in a sticky write-one-to-clear status register.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   data_req/we/be/addr/wdata bus request side (gnt = req, no stall)
//   data_gnt                 grant
//   data_rvalid/rdata/err    registered response, one cycle after grant
//   gpio_out  [OUT_WIDTH]    output pins
//   gpio_in   [IN_WIDTH]     asynchronous input pins
//   irq                      level interrupt, registered |IRQ_STATUS
module gpio_irq_controller
  import gpio_pkg::*;
#(
  parameter int OUT_WIDTH   = 18,
  parameter int IN_WIDTH    = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 data_req,
  input  logic                 data_we,
  input  logic [3:0]           data_be,
  input  logic [31:0]          data_addr,
  input  logic [31:0]          data_wdata,
  output logic                 data_gnt,
  output logic                 data_rvalid,
  output logic [31:0]          data_rdata,
  output logic                 data_err,
  output logic [OUT_WIDTH-1:0] gpio_out,
  input  logic [IN_WIDTH-1:0]  gpio_in,
  output logic                 irq
);

  // Registers
  logic [OUT_WIDTH-1:0] r_out;
  logic [IN_WIDTH-1:0]  r_rise_en;
  logic [IN_WIDTH-1:0]  r_fall_en;
  logic [IN_WIDTH-1:0]  r_stat;
  logic                 r_irq;
  logic                 r_rvalid;
  logic [31:0]          r_rdata;
  logic                 r_err;

  // Decode
  logic [ADDR_BITS-1:0] w_off;
  logic                 w_err;
  logic                 w_wr;
  logic                 w_rd;
  logic [31:0]          w_bm;
  logic [31:0]          w_wbits;
  logic                 w_unused;

  // Next-state and datapath
  logic [OUT_WIDTH-1:0] w_out_nxt;
  logic [IN_WIDTH-1:0]  w_rise_en_nxt;
  logic [IN_WIDTH-1:0]  w_fall_en_nxt;
  logic [IN_WIDTH-1:0]  w_w1c;
  logic [IN_WIDTH-1:0]  w_set;
  logic [IN_WIDTH-1:0]  w_sync;
  logic [IN_WIDTH-1:0]  w_rise;
  logic [IN_WIDTH-1:0]  w_fall;
  logic [31:0]          w_rdata;

  gpio_edge_sync #(
    .WIDTH  (IN_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk      (clk),
    .rst      (rst),
    .din      (gpio_in),
    .sync_val (w_sync),
    .rise     (w_rise),
    .fall     (w_fall)
  );

  assign w_off    = data_addr[ADDR_BITS-1:0];
  // Upper address bits are decoded upstream.
  assign w_unused = &{1'b0, data_addr[31:ADDR_BITS]};

  // Error: out of window, misaligned, or write to the read-only IN register.
  assign w_err = (w_off >= GPIO_REG_END) || (data_addr[1:0] != 2'b00) ||
                 (data_we && (w_off == GPIO_IN));

  assign w_wr    = data_req && data_we && !w_err;
  assign w_rd    = data_req && !data_we && !w_err;
  assign w_bm    = be_mask(data_be);
  // Write data with disabled byte lanes forced to zero, so that SET/CLR/TGL
  // and W1C operate only on enabled lanes.
  assign w_wbits = data_wdata & w_bm;

  always_comb begin
    w_out_nxt     = r_out;
    w_rise_en_nxt = r_rise_en;
    w_fall_en_nxt = r_fall_en;
    w_w1c         = '0;
    if (w_wr) begin
      case (w_off)
        GPIO_OUT:        w_out_nxt = (r_out & ~w_bm[OUT_WIDTH-1:0]) |
                                     w_wbits[OUT_WIDTH-1:0];
        GPIO_SET:        w_out_nxt = r_out | w_wbits[OUT_WIDTH-1:0];
        GPIO_CLR:        w_out_nxt = r_out & ~w_wbits[OUT_WIDTH-1:0];
        GPIO_TGL:        w_out_nxt = r_out ^ w_wbits[OUT_WIDTH-1:0];
        GPIO_RISE_EN:    w_rise_en_nxt = (r_rise_en & ~w_bm[IN_WIDTH-1:0]) |
                                         w_wbits[IN_WIDTH-1:0];
        GPIO_FALL_EN:    w_fall_en_nxt = (r_fall_en & ~w_bm[IN_WIDTH-1:0]) |
                                         w_wbits[IN_WIDTH-1:0];
        GPIO_IRQ_STATUS: w_w1c = w_wbits[IN_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  assign w_set = (w_rise & r_rise_en) | (w_fall & r_fall_en);

  always_comb begin
    w_rdata = '0;
    case (w_off)
      GPIO_OUT:        w_rdata[OUT_WIDTH-1:0] = r_out;
      GPIO_IN:         w_rdata[IN_WIDTH-1:0]  = w_sync;
      GPIO_RISE_EN:    w_rdata[IN_WIDTH-1:0]  = r_rise_en;
      GPIO_FALL_EN:    w_rdata[IN_WIDTH-1:0]  = r_fall_en;
      GPIO_IRQ_STATUS: w_rdata[IN_WIDTH-1:0]  = r_stat;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out     <= '0;
      r_rise_en <= '0;
      r_fall_en <= '0;
      r_stat    <= '0;
      r_irq     <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_out     <= w_out_nxt;
      r_rise_en <= w_rise_en_nxt;
      r_fall_en <= w_fall_en_nxt;
      // Set term is ORed after the clear so a coincident event wins.
      r_stat    <= (r_stat & ~w_w1c) | w_set;
      r_irq     <= |r_stat;
      r_rvalid  <= data_req;
      r_rdata   <= w_rd ? w_rdata : '0;
      r_err     <= data_req && w_err;
    end
  end

  assign data_gnt    = data_req;
  assign data_rvalid = r_rvalid;
  assign data_rdata  = r_rdata;
  assign data_err    = r_err;
  assign gpio_out    = r_out;
  assign irq         = r_irq;

endmodule

// File: tb/tb_gpio_irq_controller.sv
module tb_gpio_irq_controller;

  logic        clk;
  logic        rst;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        data_err;
  logic [17:0] gpio_out;
  logic [11:0] gpio_in;
  logic        irq;

  int n_chk;
  int n_err;

  logic [31:0] rd;
  logic        er;

  gpio_irq_controller #(
    .OUT_WIDTH   (18),
    .IN_WIDTH    (12),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data_req    (data_req),
    .data_we     (data_we),
    .data_be     (data_be),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_gnt    (data_gnt),
    .data_rvalid (data_rvalid),
    .data_rdata  (data_rdata),
    .data_err    (data_err),
    .gpio_out    (gpio_out),
    .gpio_in     (gpio_in),
    .irq         (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at the next posedge+1 with the response sampled.
  task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] be, output logic [31:0] r, output logic e);
    data_req   = 1'b1;
    data_we    = we;
    data_addr  = addr;
    data_wdata = wd;
    data_be    = be;
    #1;
    chk("gnt", 32'(data_gnt), 32'd1);
    @(posedge clk); #1;
    chk("rvalid", 32'(data_rvalid), 32'd1);
    r = data_rdata;
    e = data_err;
    data_req   = 1'b0;
    data_we    = 1'b0;
    data_addr  = '0;
    data_wdata = '0;
    data_be    = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b0;
    data_req = 1'b0; data_we = 1'b0; data_be = '0; data_addr = '0; data_wdata = '0;
    gpio_in = '0;
    #1;
    chk("rst_gpio_out", 32'(gpio_out), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_rvalid", 32'(data_rvalid), 32'h0);
    chk("rst_rdata", data_rdata, 32'h0);
    chk("rst_err", 32'(data_err), 32'h0);
    #11 rst = 1'b1;
    @(posedge clk); #1;

    // Reads after reset
    bus(1'b0, 32'h00, 0, 4'hF, rd, er); chk("rd_out0", rd, 0); chk("rd_out0_err", 32'(er), 0);
    bus(1'b0, 32'h10, 0, 4'hF, rd, er); chk("rd_in0", rd, 0);  chk("rd_in0_err", 32'(er), 0);
    bus(1'b0, 32'h1C, 0, 4'hF, rd, er); chk("rd_st0", rd, 0);  chk("rd_st0_err", 32'(er), 0);
    chk("gpio_out_0", 32'(gpio_out), 0);
    chk("irq_0", 32'(irq), 0);

    // Byte-enabled writes and atomic ops
    bus(1'b1, 32'h00, 32'h0003_FFFF, 4'b0011, rd, er); chk("out_be0011", 32'(gpio_out), 32'h0FFFF);
    bus(1'b1, 32'h00, 32'h0003_FFFF, 4'b0100, rd, er); chk("out_be0100", 32'(gpio_out), 32'h3FFFF);
    bus(1'b1, 32'h04, 32'h0, 4'hF, rd, er);            chk("set0", 32'(gpio_out), 32'h3FFFF);
    bus(1'b1, 32'h08, 32'h0000_000F, 4'hF, rd, er);    chk("clrF", 32'(gpio_out), 32'h3FFF0);
    bus(1'b1, 32'h0C, 32'h0003_0000, 4'hF, rd, er);    chk("tgl", 32'(gpio_out), 32'h0FFF0);
    bus(1'b0, 32'h04, 0, 4'hF, rd, er); chk("rd_wo", rd, 0); chk("rd_wo_err", 32'(er), 0);
    bus(1'b1, 32'h00, 32'hFFFF_FFFF, 4'hF, rd, er);
    bus(1'b0, 32'h00, 0, 4'hF, rd, er); chk("rd_out_unimpl", rd, 32'h3FFFF);

    // Back-to-back write then read
    data_req = 1'b1; data_we = 1'b1; data_addr = 32'h00; data_wdata = 32'h5; data_be = 4'hF;
    @(posedge clk); #1;
    chk("b2b_rvalid_w", 32'(data_rvalid), 1);
    chk("b2b_err_w", 32'(data_err), 0);
    chk("b2b_out", 32'(gpio_out), 32'h5);
    data_we = 1'b0; data_wdata = '0;
    @(posedge clk); #1;
    chk("b2b_rvalid_r", 32'(data_rvalid), 1);
    chk("b2b_rdata", data_rdata, 32'h5);
    data_req = 1'b0;
    @(posedge clk); #1;
    chk("idle_rvalid", 32'(data_rvalid), 0);
    chk("idle_rdata", data_rdata, 0);
    chk("idle_err", 32'(data_err), 0);

    // Edge interrupts
    gpio_in = 12'h800;
    idle(4);
    bus(1'b0, 32'h10, 0, 4'hF, rd, er); chk("rd_in_800", rd, 32'h800);
    bus(1'b1, 32'h14, 32'h001, 4'hF, rd, er);
    bus(1'b1, 32'h18, 32'h800, 4'hF, rd, er);
    bus(1'b0, 32'h14, 0, 4'hF, rd, er); chk("rd_rise_en", rd, 32'h001);
    bus(1'b0, 32'h18, 0, 4'hF, rd, er); chk("rd_fall_en", rd, 32'h800);
    bus(1'b0, 32'h1C, 0, 4'hF, rd, er); chk("st_pre", rd, 0);

    gpio_in = 12'h801;                 // bit0 rises
    idle(2);
    bus(1'b0, 32'h1C, 0, 4'hF, rd, er); chk("st_rise_early", rd, 32'h000); chk("irq_early", 32'(irq), 0);
    bus(1'b0, 32'h1C, 0, 4'hF, rd, er); chk("st_rise", rd, 32'h001);       chk("irq_rise", 32'(irq), 1);
    gpio_in = 12'h001;                 // bit11 falls
    idle(2);
    bus(1'b0, 32'h1C, 0, 4'hF, rd, er); chk("st_fall_early", rd, 32'h001);
    bus(1'b0, 32'h1C, 0, 4'hF, rd, er); chk("st_fall", rd, 32'h801);
    chk("irq_fall", 32'(irq), 1);

    // W1C with byte enables: lane 0 clears bit0, lane 1 clears bit11
    bus(1'b1, 32'h1C, 32'h801, 4'b0001, rd, er);
    bus(1'b0, 32'h1C, 0, 4'hF, rd, er); chk("w1c_lane0", rd, 32'h800);
    bus(1'b1, 32'h1C, 32'h801, 4'b0010, rd, er);
    chk("irq_w1c_1st", 32'(irq), 1);
    idle(1);
    chk("irq_w1c_2nd", 32'(irq), 0);
    bus(1'b0, 32'h1C, 0, 4'hF, rd, er); chk("w1c_all", rd, 0);

    // Set wins over coincident W1C
    gpio_in = 12'h000; idle(4);
    gpio_in = 12'h001; idle(5);
    bus(1'b0, 32'h1C, 0, 4'hF, rd, er); chk("st_before_race", rd, 32'h001);
    gpio_in = 12'h000; idle(4);
    gpio_in = 12'h001; idle(2);
    bus(1'b1, 32'h1C, 32'h001, 4'hF, rd, er);
    chk("irq_race", 32'(irq), 1);
    bus(1'b0, 32'h1C, 0, 4'hF, rd, er); chk("st_race", rd, 32'h001);
    chk("irq_race2", 32'(irq), 1);

    // Clearing an enable keeps pending status
    bus(1'b1, 32'h14, 32'h0, 4'hF, rd, er);
    bus(1'b0, 32'h1C, 0, 4'hF, rd, er); chk("st_en_off", rd, 32'h001);
    bus(1'b1, 32'h1C, 32'h001, 4'hF, rd, er);
    bus(1'b0, 32'h1C, 0, 4'hF, rd, er); chk("st_cleared", rd, 0);
    chk("irq_cleared", 32'(irq), 0);

    // Error cases
    bus(1'b0, 32'h20, 0, 4'hF, rd, er); chk("err_rd20", 32'(er), 1); chk("err_rd20_data", rd, 0);
    bus(1'b1, 32'h10, 32'hFFF, 4'hF, rd, er); chk("err_wr10", 32'(er), 1); chk("err_wr10_data", rd, 0);
    bus(1'b1, 32'h02, 32'hFFFF_FFFF, 4'hF, rd, er); chk("err_wr02", 32'(er), 1);
    bus(1'b0, 32'h02, 0, 4'hF, rd, er); chk("err_rd02", 32'(er), 1); chk("err_rd02_data", rd, 0);
    bus(1'b1, 32'h34, 32'hFFFF_FFFF, 4'hF, rd, er); chk("err_wr34", 32'(er), 1);
    chk("err_out_kept", 32'(gpio_out), 32'h5);
    bus(1'b0, 32'h14, 0, 4'hF, rd, er); chk("err_rise_kept", rd, 0);
    bus(1'b0, 32'h18, 0, 4'hF, rd, er); chk("err_fall_kept", rd, 32'h800);
    bus(1'b0, 32'h10, 0, 4'hF, rd, er); chk("err_in_kept", rd, 32'h001);

    // Asynchronous reset with a response pending
    bus(1'b1, 32'h00, 32'h3FFFF, 4'hF, rd, er); chk("pre_rst_out", 32'(gpio_out), 32'h3FFFF);
    bus(1'b1, 32'h14, 32'h001, 4'hF, rd, er);
    gpio_in = 12'h000; idle(4);
    gpio_in = 12'h001; idle(5);
    chk("pre_rst_irq", 32'(irq), 1);
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h00; data_be = 4'hF;
    @(posedge clk); #1;
    chk("pre_rst_rvalid", 32'(data_rvalid), 1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_out", 32'(gpio_out), 0);
    chk("async_rst_rvalid", 32'(data_rvalid), 0);
    chk("async_rst_irq", 32'(irq), 0);
    chk("async_rst_rdata", data_rdata, 0);
    data_req = 1'b0;
    @(posedge clk); #1;
    chk("rst_hold_rvalid", 32'(data_rvalid), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/gpio_irq_controller.md
Name: gpio_irq_controller

Overview:
Parametrised successor to the fixed 18-out/12-in GPIO controller. It adds configurable pin counts, input synchronisation, atomic set/clear/toggle of outputs, and per-pin rising/falling-edge interrupts with a sticky W1C status register. It sits inside the peripheral block on the core data bus (req/gnt/rvalid/err) and drives one level interrupt line.

Parameters:
OUT_WIDTH, 18, number of output pins (1..32)
IN_WIDTH, 12, number of input pins (1..32)
SYNC_STAGES, 2, input synchroniser depth (>=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
data_req  in  1  bus request
data_we  in  1  1=write, 0=read
data_be  in  4  byte enables, writes only
data_addr  in  32  byte address; only [7:2] decoded, upper bits decoded upstream
data_wdata  in  32  write data
data_gnt  out  1  grant
data_rvalid  out  1  response valid
data_rdata  out  32  read data
data_err  out  1  error response, qualified by rvalid
gpio_out  out  OUT_WIDTH  output pins
gpio_in  in  IN_WIDTH  asynchronous input pins
irq  out  1  level interrupt, = |IRQ_STATUS

Behaviour:
- Register map (offset = data_addr[7:0]):
  0x00 OUT RW; 0x04 OUT_SET WO; 0x08 OUT_CLR WO; 0x0C OUT_TGL WO; 0x10 IN RO; 0x14 RISE_EN RW; 0x18 FALL_EN RW; 0x1C IRQ_STATUS RW1C.
- Unimplemented bits (above OUT_WIDTH or IN_WIDTH) read 0; writes to them are ignored.
- Bus handshake:
  - data_gnt = data_req, combinational; no stall.
  - Every granted request gets exactly one rvalid pulse in the following cycle.
  - Back-to-back requests every cycle are supported.
- Writes: bytes with data_be[i]=0 are untouched. This applies to SET, CLR, TGL and W1C lanes too. The register update is visible on the cycle after grant.
- Reads: data_rdata is registered and presented with rvalid. data_be is ignored on reads. Reads of WO registers return 0 without error.
- Errors: data_err=1 with rvalid, rdata=0, no state change, for:
  - offset >= 0x20;
  - a write to IN (0x10);
  - data_addr[1:0] != 0.
- Idle outputs: when rvalid=0, data_rdata=0 and data_err=0.
- Inputs: gpio_in passes through SYNC_STAGES flops. IN reads the final stage. One further flop holds the previous value for edge detection.
- Edge detection:
  - rise[i] = sync & ~prev; fall[i] = ~sync & prev.
  - Status set term = (rise & RISE_EN) | (fall & FALL_EN).
  - A pin toggle reaches IRQ_STATUS SYNC_STAGES+1 cycles after it is stable at gpio_in.
  - irq is registered from status, so it asserts one cycle after the status bit is set.
- Simultaneous events:
  - A set term and a W1C of the same IRQ_STATUS bit in the same cycle: set wins, bit stays 1.
  - Clearing an enable does not clear pending status.
- Reset (async assert, sync-safe deassert handled upstream):
  - OUT, RISE_EN, FALL_EN, IRQ_STATUS, sync and prev flops = 0.
  - gpio_out=0, irq=0, rvalid=0, rdata=0, err=0.
  - A reset mid-transaction drops the pending response.

Decomposition:
- Package gpio_pkg holds:
  - register offset localparams (GPIO_OUT, GPIO_SET, GPIO_CLR, GPIO_TGL, GPIO_IN, GPIO_RISE_EN, GPIO_FALL_EN, GPIO_IRQ_STATUS);
  - the decode width constant (ADDR_BITS=8);
  - a function applying a 4-bit byte-enable mask to a 32-bit word.
- Sub-module gpio_edge_sync (parameters WIDTH, STAGES) holds the synchroniser plus prev flop. Outputs: sync_val, rise, fall.

Test Plan:
- Reset, then read 0x00, 0x10, 0x1C.
  - Expect rvalid one cycle after each req, rdata=0, err=0, gpio_out=0, irq=0.
- Write OUT=0x0003_FFFF with be=4'b0011, then be=4'b0100.
  - Expect gpio_out=0x0FFFF, then 0x3FFFF.
  - Then SET 0x0, CLR 0x0000_000F, TGL 0x0003_0000: expect gpio_out=0x0FFF0.
- Back-to-back: write OUT=0x5 on cycle N and read OUT on cycle N+1.
  - Expect rvalid on N+1 and N+2, with read rdata=0x5.
- RISE_EN=0x001, FALL_EN=0x800. Drive gpio_in[0] 0->1, then gpio_in[11] 1->0.
  - Expect IRQ_STATUS=0x001 exactly 3 cycles after the pin change (SYNC_STAGES=2), then 0x801.
  - Expect irq=1 one cycle later.
  - Write 0x1C=0x801: expect irq=0 in the second cycle after grant.
- Hold gpio_in[0] rising in the same cycle as a W1C 0x1C=0x001 takes effect.
  - Expect bit 0 stays 1 and irq stays 1.
- Error cases: read 0x20, write 0x10, access 0x02.
  - Expect err=1 with rvalid and rdata=0 for each, and all registers unchanged.
- Assert rst low mid-run with OUT=0x3FFFF and a response pending.
  - Expect gpio_out=0, rvalid=0 and irq=0 immediately, with no clock edge needed.
